mem_channel_arbiter: RTL and testbench
======================================

// Module: mem_channel_arbiter
// PURPOSE
//  Multi-channel memory arbiter between NUM_CONSUMERS requesters (LSUs/fetchers) and NUM_CHANNELS memory ports.
//  Each channel runs a handshake FSM: it holds a grant until memory acknowledges, relays the response,
//  then releases. Grants rotate round-robin across consumers. Used for both data memory (WRITE_ENABLE=1)
//  and program memory (WRITE_ENABLE=0).
// PARAMETERS
//  ADDR_BITS      8  address width
//  DATA_BITS      8  data width (16 for program memory)
//  NUM_CONSUMERS  4  requesters, >=1
//  NUM_CHANNELS   2  memory channels, 1..NUM_CONSUMERS
//  WRITE_ENABLE   1  0: write ports ignored, write outputs tied 0
// PORTS
//  clk                    in   1                      clock, rising edge
//  reset                  in   1                      asynchronous, active-low
//  consumer_read_valid    in   NUM_CONSUMERS          read request, held until ready seen
//  consumer_read_address  in   NUM_CONSUMERS*ADDR_BITS per-consumer read address
//  consumer_read_ready    out  NUM_CONSUMERS          1-cycle pulse, data valid
//  consumer_read_data     out  NUM_CONSUMERS*DATA_BITS per-consumer read data, held after pulse
//  consumer_write_valid   in   NUM_CONSUMERS          write request, held until ready seen
//  consumer_write_address in   NUM_CONSUMERS*ADDR_BITS per-consumer write address
//  consumer_write_data    in   NUM_CONSUMERS*DATA_BITS per-consumer write data
//  consumer_write_ready   out  NUM_CONSUMERS          1-cycle pulse, write done
//  mem_read_valid         out  NUM_CHANNELS           read request, held until mem_read_ready
//  mem_read_address       out  NUM_CHANNELS*ADDR_BITS  channel read address
//  mem_read_ready         in   NUM_CHANNELS           memory ack; mem_read_data valid same cycle
//  mem_read_data          in   NUM_CHANNELS*DATA_BITS  channel read data
//  mem_write_valid        out  NUM_CHANNELS           write request, held until mem_write_ready
//  mem_write_address      out  NUM_CHANNELS*ADDR_BITS  channel write address
//  mem_write_data         out  NUM_CHANNELS*DATA_BITS  channel write data
//  mem_write_ready        in   NUM_CHANNELS           memory write ack
// BEHAVIOUR
//  Reset (reset=0, async): all outputs 0, all channels IDLE, rr_ptr=0, owner mask clear.
//  Per-channel FSM:
//    IDLE: pick a consumer (see arbitration); read -> RD_WAIT, else write -> WR_WAIT. Next cycle
//          mem_*_valid=1 with latched addr/data.
//    RD_WAIT: hold valid/address; on mem_read_ready latch data, drop valid -> RELAY.
//    WR_WAIT: same for writes, on mem_write_ready -> RELAY.
//    RELAY: consumer_*_ready pulses 1 cycle (read data driven same cycle) -> RELEASE.
//    RELEASE: wait until the owner's valid for that op is 0, then clear owner -> IDLE.
//  Min latency: request at t, mem valid t+1, ready at t+1 gives consumer ready at t+2.
//  Arbitration: a consumer is eligible if it has read/write valid and is not owned by any channel.
//    IDLE channels are scanned in index order, lowest first; each takes the first eligible consumer
//    from rr_ptr upward (mod NUM_CONSUMERS), excluding consumers taken by lower channels this cycle.
//    If both read and write are valid for one consumer, read wins.
//    rr_ptr <= (last consumer granted this cycle + 1) mod NUM_CONSUMERS; unchanged if no grant.
//  Index arithmetic uses CONSUMER_BITS+1 wide sums with explicit wrap; no width truncation.
//  Simultaneous events: release and new grant of the same consumer never happen in one cycle
//    (owner clears end of RELEASE, eligible next cycle).
//  WRITE_ENABLE=0: write valids ignored, write outputs constant 0, WR_WAIT unreachable.
//  More channels free than requests: surplus channels stay IDLE, valid 0.
//  Memory ready while channel not waiting: ignored.
//  Reset mid-transaction: aborts; no ready pulse issued for the in-flight request.
// TESTING
//  1. Single read: C0 reads addr 0x12, mem ready 1 cycle after valid with 0xA5
//     -> ch0 addr 0x12; C0 read_ready pulses once with data 0xA5 at t+2.
//  2. Fairness: 4 consumers reading continuously, 1 channel, ready immediate
//     -> grant order 0,1,2,3,0...; no consumer served twice before the rest.
//  3. Parallel: 2 channels, C1 and C3 request same cycle
//     -> ch0 gets C1, ch1 gets C3 (rr_ptr=0); both relayed; rr_ptr becomes 0.
//  4. Backpressure: mem_write_ready low 5 cycles
//     -> mem_write_valid, addr and data stable all 5 cycles; single write_ready pulse after ack.
//  5. WRITE_ENABLE=0: write_valid=1 on all consumers -> mem_write_valid stays 0; reads unaffected.
//  6. Async reset asserted in RD_WAIT -> outputs 0 immediately; after release, no stale ready pulse.

Source files
------------

// File: rtl/mem_channel_arbiter.sv
// Multi-channel memory arbiter: NUM_CONSUMERS requesters share NUM_CHANNELS
// memory ports. Each channel runs a request/ack/relay/release handshake, and
// idle channels pick new owners round-robin starting from rr_ptr.
module mem_channel_arbiter #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 2,
  parameter int WRITE_ENABLE  = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]            mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]            mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

  localparam int CONSUMER_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam int IDX_W         = CONSUMER_BITS + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_WR_WAIT,
    S_RELAY,
    S_RELEASE
  } state_t;

  state_t                   state_q   [NUM_CHANNELS];
  state_t                   state_d   [NUM_CHANNELS];
  logic [CONSUMER_BITS-1:0] owner_q   [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]  op_read_q;
  logic [ADDR_BITS-1:0]     addr_q    [NUM_CHANNELS];
  logic [DATA_BITS-1:0]     wdata_q   [NUM_CHANNELS];
  logic [DATA_BITS-1:0]     rdata_q   [NUM_CONSUMERS];
  logic [CONSUMER_BITS-1:0] rr_ptr_q;

  logic [NUM_CONSUMERS-1:0] wr_req;
  logic [NUM_CONSUMERS-1:0] owned;
  logic [NUM_CONSUMERS-1:0] taken;
  logic [NUM_CHANNELS-1:0]  grant_en;
  logic [NUM_CHANNELS-1:0]  grant_rd;
  logic [CONSUMER_BITS-1:0] grant_idx [NUM_CHANNELS];
  logic                     any_grant;
  logic                     found;
  logic [IDX_W-1:0]         cand;
  logic [CONSUMER_BITS-1:0] last_grant;
  logic [IDX_W-1:0]         rr_sum;
  logic [CONSUMER_BITS-1:0] rr_next;

  // Write requests are masked off entirely on read-only instances.
  assign wr_req = (WRITE_ENABLE != 0) ? consumer_write_valid : '0;

  // Consumers currently held by any non-idle channel.
  always_comb begin
    owned = '0;
    for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
      if (state_q[ch] != S_IDLE) owned[owner_q[ch]] = 1'b1;
    end
  end

  // Idle channels in index order each claim the first eligible consumer from rr_ptr upward.
  always_comb begin
    taken      = owned;
    grant_en   = '0;
    grant_rd   = '0;
    grant_idx  = '{default: '0};
    any_grant  = 1'b0;
    found      = 1'b0;
    cand       = '0;
    last_grant = '0;
    for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
      found = 1'b0;
      if (state_q[ch] == S_IDLE) begin
        for (int unsigned k = 0; k < NUM_CONSUMERS; k++) begin
          cand = IDX_W'(rr_ptr_q) + IDX_W'(k);
          if (cand >= IDX_W'(NUM_CONSUMERS)) cand = cand - IDX_W'(NUM_CONSUMERS);
          if (!found && !taken[cand[CONSUMER_BITS-1:0]] &&
              (consumer_read_valid[cand[CONSUMER_BITS-1:0]] || wr_req[cand[CONSUMER_BITS-1:0]])) begin
            found         = 1'b1;
            grant_en[ch]  = 1'b1;
            grant_idx[ch] = cand[CONSUMER_BITS-1:0];
            grant_rd[ch]  = consumer_read_valid[cand[CONSUMER_BITS-1:0]];
            taken[cand[CONSUMER_BITS-1:0]] = 1'b1;
            any_grant     = 1'b1;
            last_grant    = cand[CONSUMER_BITS-1:0];
          end
        end
      end
    end
  end

  // Pointer advances to one past the highest-channel grant of this cycle.
  always_comb begin
    rr_sum = IDX_W'(last_grant) + IDX_W'(1);
    if (rr_sum >= IDX_W'(NUM_CONSUMERS)) rr_sum = rr_sum - IDX_W'(NUM_CONSUMERS);
    rr_next = rr_sum[CONSUMER_BITS-1:0];
  end

  // Per-channel handshake next-state.
  always_comb begin
    for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
      state_d[ch] = state_q[ch];
      case (state_q[ch])
        S_IDLE:    if (grant_en[ch]) state_d[ch] = grant_rd[ch] ? S_RD_WAIT : S_WR_WAIT;
        S_RD_WAIT: if (mem_read_ready[ch]) state_d[ch] = S_RELAY;
        S_WR_WAIT: if (mem_write_ready[ch]) state_d[ch] = S_RELAY;
        S_RELAY:   state_d[ch] = S_RELEASE;
        S_RELEASE: begin
          if (op_read_q[ch] ? !consumer_read_valid[owner_q[ch]] : !wr_req[owner_q[ch]])
            state_d[ch] = S_IDLE;
        end
        default:   state_d[ch] = S_IDLE;
      endcase
    end
  end

  // Channel state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) state_q[ch] <= S_IDLE;
    end else begin
      for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) state_q[ch] <= state_d[ch];
    end
  end

  // Latch owner, direction, address and write data at grant time.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_read_q <= '0;
      for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
        owner_q[ch] <= '0;
        addr_q[ch]  <= '0;
        wdata_q[ch] <= '0;
      end
    end else begin
      for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
        if (grant_en[ch]) begin
          owner_q[ch]   <= grant_idx[ch];
          op_read_q[ch] <= grant_rd[ch];
          addr_q[ch]    <= grant_rd[ch]
                         ? consumer_read_address[grant_idx[ch]*ADDR_BITS +: ADDR_BITS]
                         : consumer_write_address[grant_idx[ch]*ADDR_BITS +: ADDR_BITS];
          wdata_q[ch]   <= consumer_write_data[grant_idx[ch]*DATA_BITS +: DATA_BITS];
        end
      end
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         rr_ptr_q <= '0;
    else if (any_grant) rr_ptr_q <= rr_next;
  end

  // Per-consumer read data, captured on memory ack and held until the next read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned c = 0; c < NUM_CONSUMERS; c++) rdata_q[c] <= '0;
    end else begin
      for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
        if (state_q[ch] == S_RD_WAIT && mem_read_ready[ch])
          rdata_q[owner_q[ch]] <= mem_read_data[ch*DATA_BITS +: DATA_BITS];
      end
    end
  end

  // Memory-side requests and consumer-side ready pulses decoded from channel state.
  always_comb begin
    mem_read_valid       = '0;
    mem_read_address     = '0;
    mem_write_valid      = '0;
    mem_write_address    = '0;
    mem_write_data       = '0;
    consumer_read_ready  = '0;
    consumer_write_ready = '0;
    consumer_read_data   = '0;
    for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
      mem_read_valid[ch] = (state_q[ch] == S_RD_WAIT);
      mem_read_address[ch*ADDR_BITS +: ADDR_BITS] = addr_q[ch];
      if (WRITE_ENABLE != 0) begin
        mem_write_valid[ch] = (state_q[ch] == S_WR_WAIT);
        mem_write_address[ch*ADDR_BITS +: ADDR_BITS] = addr_q[ch];
        mem_write_data[ch*DATA_BITS +: DATA_BITS]    = wdata_q[ch];
      end
      if (state_q[ch] == S_RELAY) begin
        if (op_read_q[ch])          consumer_read_ready[owner_q[ch]]  = 1'b1;
        else if (WRITE_ENABLE != 0) consumer_write_ready[owner_q[ch]] = 1'b1;
      end
    end
    for (int unsigned c = 0; c < NUM_CONSUMERS; c++)
      consumer_read_data[c*DATA_BITS +: DATA_BITS] = rdata_q[c];
  end

endmodule

// File: tb/tb_mem_channel_arbiter.sv
// Bench for mem_channel_arbiter: directed handshake/arbitration scenarios plus
// randomized traffic against a behavioural memory, consumer agent and responder.
module tb_mem_channel_arbiter;
  localparam int AB  = 8;
  localparam int DB  = 8;
  localparam int NC  = 4;
  localparam int NCH = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Read/write instance
  logic [NC-1:0]     a_crv, a_crr, a_cwv, a_cwr;
  logic [NC*AB-1:0]  a_cra, a_cwa;
  logic [NC*DB-1:0]  a_crd, a_cwd;
  logic [NCH-1:0]    a_mrv, a_mrr, a_mwv, a_mwr;
  logic [NCH*AB-1:0] a_mra, a_mwa;
  logic [NCH*DB-1:0] a_mrd, a_mwd;
  // Read-only instance
  logic [NC-1:0]     b_crv, b_crr, b_cwv, b_cwr;
  logic [NC*AB-1:0]  b_cra, b_cwa;
  logic [NC*DB-1:0]  b_crd, b_cwd;
  logic [NCH-1:0]    b_mrv, b_mrr, b_mwv, b_mwr;
  logic [NCH*AB-1:0] b_mra, b_mwa;
  logic [NCH*DB-1:0] b_mrd, b_mwd;

  mem_channel_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC),
                        .NUM_CHANNELS(NCH), .WRITE_ENABLE(1)) u_rw (
    .clk(clk), .reset(reset),
    .consumer_read_valid(a_crv), .consumer_read_address(a_cra),
    .consumer_read_ready(a_crr), .consumer_read_data(a_crd),
    .consumer_write_valid(a_cwv), .consumer_write_address(a_cwa),
    .consumer_write_data(a_cwd), .consumer_write_ready(a_cwr),
    .mem_read_valid(a_mrv), .mem_read_address(a_mra),
    .mem_read_ready(a_mrr), .mem_read_data(a_mrd),
    .mem_write_valid(a_mwv), .mem_write_address(a_mwa),
    .mem_write_data(a_mwd), .mem_write_ready(a_mwr));

  mem_channel_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC),
                        .NUM_CHANNELS(NCH), .WRITE_ENABLE(0)) u_ro (
    .clk(clk), .reset(reset),
    .consumer_read_valid(b_crv), .consumer_read_address(b_cra),
    .consumer_read_ready(b_crr), .consumer_read_data(b_crd),
    .consumer_write_valid(b_cwv), .consumer_write_address(b_cwa),
    .consumer_write_data(b_cwd), .consumer_write_ready(b_cwr),
    .mem_read_valid(b_mrv), .mem_read_address(b_mra),
    .mem_read_ready(b_mrr), .mem_read_data(b_mrd),
    .mem_write_valid(b_mwv), .mem_write_address(b_mwa),
    .mem_write_data(b_mwd), .mem_write_ready(b_mwr));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int served = 0;
  int issued = 0;

  logic [7:0] mem [256];
  bit   [NC-1:0] pend_rd, pend_wr;
  logic [7:0] exp_rd [NC];
  logic [7:0] exp_wd [NC];
  int drop_cyc [NC];
  int rcnt [NCH];
  int wcnt [NCH];
  int rlat [NCH];
  int wlat [NCH];
  logic [7:0] rhold_a [NCH];
  logic [7:0] whold_a [NCH];
  logic [7:0] whold_d [NCH];
  int lat_mode = 0;
  int rd_lat_fix = 0;
  int wr_lat_fix = 0;
  int grant_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req_rd(input int i, input logic [7:0] ad);
    exp_rd[i] = mem[ad];
    pend_rd[i] = 1'b1;
    issued++;
    a_cra[i*AB +: AB] = ad;
    a_crv[i] = 1'b1;
  endtask

  task automatic req_wr(input int i, input logic [7:0] ad, input logic [7:0] d);
    exp_wd[i] = d;
    pend_wr[i] = 1'b1;
    issued++;
    a_cwa[i*AB +: AB] = ad;
    a_cwd[i*DB +: DB] = d;
    a_cwv[i] = 1'b1;
  endtask

  // One cycle: at the falling edge run the consumer agent and memory responder.
  task automatic tick();
    logic [7:0] ad;
    logic [7:0] dt;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NC; i++) begin
      if (a_crr[i]) begin
        chk("rd_ready_expected", 32'(pend_rd[i]), 32'd1);
        chk("rd_data", 32'(a_crd[i*DB +: DB]), 32'(exp_rd[i]));
        pend_rd[i] = 1'b0; a_crv[i] = 1'b0; drop_cyc[i] = cyc; served++;
      end
      if (a_cwr[i]) begin
        chk("wr_ready_expected", 32'(pend_wr[i]), 32'd1);
        pend_wr[i] = 1'b0; a_cwv[i] = 1'b0; drop_cyc[i] = cyc; served++;
      end
    end
    for (int ch = 0; ch < NCH; ch++) begin
      if (a_mrv[ch]) begin
        ad = a_mra[ch*AB +: AB];
        if (rcnt[ch] == 0) begin
          rhold_a[ch] = ad;
          rlat[ch] = (lat_mode != 0) ? int'($urandom_range(0, 3)) : rd_lat_fix;
          grant_q.push_back(int'(ad[1:0]));
        end else chk("rd_addr_stable", 32'(ad), 32'(rhold_a[ch]));
        if (rcnt[ch] >= rlat[ch]) begin
          a_mrr[ch] = 1'b1; a_mrd[ch*DB +: DB] = mem[ad];
        end else begin
          a_mrr[ch] = 1'b0; a_mrd[ch*DB +: DB] = 8'($urandom);
        end
        rcnt[ch]++;
      end else begin
        a_mrr[ch] = 1'b0; rcnt[ch] = 0;
      end
      if (a_mwv[ch]) begin
        ad = a_mwa[ch*AB +: AB];
        dt = a_mwd[ch*DB +: DB];
        if (wcnt[ch] == 0) begin
          whold_a[ch] = ad; whold_d[ch] = dt;
          wlat[ch] = (lat_mode != 0) ? int'($urandom_range(0, 3)) : wr_lat_fix;
        end else begin
          chk("wr_addr_stable", 32'(ad), 32'(whold_a[ch]));
          chk("wr_data_stable", 32'(dt), 32'(whold_d[ch]));
        end
        if (wcnt[ch] >= wlat[ch]) begin
          a_mwr[ch] = 1'b1;
          chk("wr_owner_pending", 32'(pend_wr[ad[1:0]]), 32'd1);
          chk("wr_data", 32'(dt), 32'(exp_wd[ad[1:0]]));
          mem[ad] = dt;
        end else a_mwr[ch] = 1'b0;
        wcnt[ch]++;
      end else begin
        a_mwr[ch] = 1'b0; wcnt[ch] = 0;
      end
    end
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((pend_rd | pend_wr) != '0 && n < limit) begin tick(); n++; end
    chk("drain_timeout", 32'(pend_rd | pend_wr), 32'd0);
    repeat (2) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ad;
    reset = 1'b0;
    a_crv = '0; a_cra = '0; a_cwv = '0; a_cwa = '0; a_cwd = '0;
    a_mrr = '0; a_mrd = '0; a_mwr = '0;
    b_crv = '0; b_cra = '0; b_cwv = '1; b_cwa = '1; b_cwd = '1;
    b_mrr = '1; b_mrd = {8'h5C, 8'h5C}; b_mwr = '1;
    pend_rd = '0; pend_wr = '0;
    for (int i = 0; i < NC; i++) drop_cyc[i] = -10;
    for (int ch = 0; ch < NCH; ch++) begin rcnt[ch] = 0; wcnt[ch] = 0; end
    for (int a = 0; a < 256; a++) mem[a] = 8'(a * 7 + 3);
    mem[8'h12] = 8'hA5;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_mem_read_valid", 32'(a_mrv), 32'd0);
    chk("rst_mem_write_valid", 32'(a_mwv), 32'd0);
    chk("rst_cons_read_ready", 32'(a_crr), 32'd0);
    chk("rst_cons_write_ready", 32'(a_cwr), 32'd0);
    chk("rst_cons_read_data", a_crd, 32'd0);
    chk("rst_mem_read_addr", 32'(a_mra), 32'd0);
    chk("rst_ro_write_addr", 32'(b_mwa), 32'd0);
    reset = 1'b1;
    tick();

    // Parallel grant with rr_ptr=0: ch0 takes C1, ch1 takes C3
    req_rd(1, 8'h41); req_rd(3, 8'h83);
    tick();
    chk("par_valid", 32'(a_mrv), 32'h3);
    chk("par_ch0_addr", 32'(a_mra[7:0]), 32'h41);
    chk("par_ch1_addr", 32'(a_mra[15:8]), 32'h83);
    tick();
    chk("par_ready", 32'(a_crr), 32'hA);
    repeat (2) tick();

    // rr_ptr wrapped back to 0: C0 and C1 win over C3
    req_rd(0, 8'h10); req_rd(1, 8'h45); req_rd(3, 8'h87);
    tick();
    chk("rr_wrap_ch0", 32'(a_mra[7:0]), 32'h10);
    chk("rr_wrap_ch1", 32'(a_mra[15:8]), 32'h45);
    drain(40);

    // Read beats write for the same consumer
    req_rd(1, 8'h49); req_wr(1, 8'h4D, 8'h77);
    tick();
    chk("prio_read_valid", 32'(a_mrv), 32'h1);
    chk("prio_write_valid", 32'(a_mwv), 32'h0);
    drain(40);

    // Single read, minimum latency
    req_rd(0, 8'h12);
    tick();
    chk("single_valid", 32'(a_mrv), 32'h1);
    chk("single_addr", 32'(a_mra[7:0]), 32'h12);
    tick();
    chk("single_ready", 32'(a_crr), 32'h1);
    chk("single_data", 32'(a_crd[7:0]), 32'hA5);
    tick();
    chk("single_ready_off", 32'(a_crr), 32'h0);
    chk("single_data_held", 32'(a_crd[7:0]), 32'hA5);
    tick();

    // Write backpressure: ready held low five cycles
    wr_lat_fix = 5;
    req_wr(2, 8'h46, 8'h3C);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_valid", 32'(a_mwv), 32'h1);
      chk("bp_addr", 32'(a_mwa[7:0]), 32'h46);
      chk("bp_data", 32'(a_mwd[7:0]), 32'h3C);
      chk("bp_no_ready", 32'(a_cwr), 32'h0);
    end
    tick();
    chk("bp_valid_at_ack", 32'(a_mwv), 32'h1);
    tick();
    chk("bp_ready_pulse", 32'(a_cwr), 32'h4);
    chk("bp_valid_dropped", 32'(a_mwv), 32'h0);
    tick();
    chk("bp_ready_off", 32'(a_cwr), 32'h0);
    tick();
    wr_lat_fix = 0;

    // Fairness: all consumers re-request continuously; last grant was C2 so order starts at C3
    grant_q.delete();
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NC; i++)
        if (!pend_rd[i] && !pend_wr[i] && cyc >= drop_cyc[i] + 2) begin
          ad = {6'($urandom), 2'(i)};
          req_rd(i, ad);
        end
      tick();
    end
    drain(40);
    chk("fair_count", 32'(grant_q.size() >= 12), 32'd1);
    for (int k = 0; k < 12 && k < grant_q.size(); k++)
      chk("fair_order", 32'(grant_q[k]), 32'((3 + k) % 4));

    // Randomized traffic with random memory latency
    lat_mode = 1;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NC; i++)
        if (!pend_rd[i] && !pend_wr[i] && cyc >= drop_cyc[i] + 2 && $urandom_range(0, 2) == 0) begin
          ad = {6'($urandom), 2'(i)};
          if ($urandom_range(0, 1) == 1) req_rd(i, ad);
          else req_wr(i, ad, 8'($urandom));
        end
      tick();
    end
    drain(80);
    chk("served_vs_issued", 32'(served), 32'(issued));
    lat_mode = 0;

    // Async reset while a read waits for memory
    rd_lat_fix = 10;
    req_rd(0, 8'h20);
    tick(); tick();
    chk("abort_in_rd_wait", 32'(a_mrv), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("abort_valid_zero", 32'(a_mrv), 32'h0);
    chk("abort_ready_zero", 32'(a_crr), 32'h0);
    chk("abort_data_zero", a_crd, 32'd0);
    a_crv = '0; pend_rd = '0; a_mrr = '0;
    rd_lat_fix = 0;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("abort_no_stale_ready", 32'(a_crr), 32'h0);
    end

    // Read-only instance: write requests ignored, reads served
    b_cra[2*AB +: AB] = 8'h33;
    b_crv[2] = 1'b1;
    tick();
    chk("ro_read_valid", 32'(b_mrv), 32'h1);
    chk("ro_read_addr", 32'(b_mra[7:0]), 32'h33);
    chk("ro_write_valid", 32'(b_mwv), 32'h0);
    tick();
    chk("ro_read_ready", 32'(b_crr), 32'h4);
    chk("ro_read_data", 32'(b_crd[2*DB +: DB]), 32'h5C);
    b_crv[2] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("ro_write_valid_idle", 32'(b_mwv), 32'h0);
      chk("ro_write_ready", 32'(b_cwr), 32'h0);
      chk("ro_write_data", 32'(b_mwd), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
